// File: rtl/icc_tx_sched.sv
// ICC GT TX lane scheduler: align K-chars, sync frames, user data.
// Fixed priority with a forced idle comma to keep far-end alignment.
module icc_tx_sched #(
  parameter int IDLE_GAP = 256,
  parameter bit SIM      = 1'b0
) (
  input  logic        txclk,
  input  logic        rstn,
  input  logic        rxbyteisaligned,
  input  logic        alignrequest,
  input  logic        sync_req,
  input  logic [4:0]  sync_action,
  input  logic [63:0] sync_word,
  output logic        sync_ack,
  output logic        sync_done,
  output logic        sync_abort,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [15:0] txdata,
  output logic [1:0]  txcharisk
);

  localparam int GAP = SIM ? 16 : IDLE_GAP;
  localparam int GW  = $clog2(GAP + 1);

  localparam logic [15:0] ALIGNREQ = 16'h01bc;
  localparam logic [15:0] COMMA    = 16'h00bc;

  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    RUN       = 2'd1,
    SYNC      = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [4:0]    act_q;
  logic [63:0]   word_q;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_n;
  logic          gap_full;
  logic [15:0]   data_n;
  logic [1:0]    k_n;
  logic          ack_n;
  logic          done_n;
  logic          abort_n;
  logic          latch;

  function automatic logic [15:0] frame_word(
    input logic [4:0]  act,
    input logic [2:0]  i,
    input logic [63:0] w
  );
    return {act, i, w[{~i, 3'b000} +: 8]};
  endfunction

  assign gap_full = (gap == GW'(GAP));

  assign din_ready = (state == RUN)
                   & rxbyteisaligned
                   & ~alignrequest
                   & ~gap_full
                   & ~sync_req;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = COMMA;
    k_n     = 2'b01;
    ack_n   = 1'b0;
    done_n  = 1'b0;
    abort_n = 1'b0;
    latch   = 1'b0;
    unique case (state)
      UNALIGNED: begin
        data_n = ALIGNREQ;
        if (rxbyteisaligned) state_n = RUN;
      end
      RUN: begin
        if (!rxbyteisaligned) begin
          data_n  = ALIGNREQ;
          state_n = UNALIGNED;
        end else if (alignrequest || gap_full) begin
          data_n = COMMA;
        end else if (sync_req) begin
          ack_n   = 1'b1;
          latch   = 1'b1;
          idx_n   = 3'd1;
          state_n = SYNC;
          data_n  = frame_word(sync_action, 3'd0,
                               sync_word);
          k_n     = 2'b00;
        end else if (din_valid) begin
          data_n = din;
          k_n    = 2'b00;
        end
      end
      SYNC: begin
        if (!rxbyteisaligned) begin
          data_n  = ALIGNREQ;
          abort_n = 1'b1;
          state_n = UNALIGNED;
        end else if (!alignrequest) begin
          data_n = frame_word(act_q, idx, word_q);
          k_n    = 2'b00;
          idx_n  = idx + 3'd1;
          if (idx == 3'd7) begin
            done_n  = 1'b1;
            state_n = RUN;
          end
        end
      end
      default: begin
        data_n  = ALIGNREQ;
        state_n = UNALIGNED;
      end
    endcase
  end

  // Any K word restarts the run; non-K words saturate at the limit.
  always_comb begin
    gap_n = gap;
    if (k_n != 2'b00) gap_n = '0;
    else if (!gap_full) gap_n = gap + GW'(1);
  end

  always_ff @(posedge txclk or negedge rstn) begin
    if (!rstn) begin
      state      <= UNALIGNED;
      idx        <= 3'd0;
      act_q      <= 5'd0;
      word_q     <= 64'd0;
      gap        <= '0;
      txdata     <= ALIGNREQ;
      txcharisk  <= 2'b01;
      sync_ack   <= 1'b0;
      sync_done  <= 1'b0;
      sync_abort <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      gap        <= gap_n;
      txdata     <= data_n;
      txcharisk  <= k_n;
      sync_ack   <= ack_n;
      sync_done  <= done_n;
      sync_abort <= abort_n;
      if (latch) begin
        act_q  <= sync_action;
        word_q <= sync_word;
      end
    end
  end

endmodule

// File: tb/tb_icc_tx_sched.sv
// Directed-vector bench for icc_tx_sched with a queued scoreboard.
// Stimulus pushes hand-computed expectations; a monitor pops them.
module tb_icc_tx_sched;

  localparam logic [15:0] A16 = 16'h01bc;
  localparam logic [15:0] C16 = 16'h00bc;
  localparam logic [15:0] FW [8] = '{
    16'h0801, 16'h0923, 16'h0a45, 16'h0b67,
    16'h0c89, 16'h0dab, 16'h0ecd, 16'h0fef
  };

  logic        txclk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxbyteisaligned = 1'b0;
  logic        alignrequest = 1'b0;
  logic        sync_req = 1'b0;
  logic [4:0]  sync_action = 5'd1;
  logic [63:0] sync_word = 64'h0123_4567_89ab_cdef;
  logic        sync_ack;
  logic        sync_done;
  logic        sync_abort;
  logic [15:0] din = 16'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;

  icc_tx_sched #(.IDLE_GAP(256), .SIM(1'b1)) dut (
    .txclk           (txclk),
    .rstn            (rstn),
    .rxbyteisaligned (rxbyteisaligned),
    .alignrequest    (alignrequest),
    .sync_req        (sync_req),
    .sync_action     (sync_action),
    .sync_word       (sync_word),
    .sync_ack        (sync_ack),
    .sync_done       (sync_done),
    .sync_abort      (sync_abort),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .txdata          (txdata),
    .txcharisk       (txcharisk)
  );

  always #5 txclk = ~txclk;

  typedef struct {
    int          due;
    bit          lane;
    logic [15:0] d;
    logic [1:0]  k;
    logic [2:0]  p;
    logic        r;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge txclk) cyc <= cyc + 1;

  always @(negedge txclk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      nvec++;
      if (e.due < cyc) begin
        nerr++;
        $display("FAIL stale due=%0d cyc=%0d", e.due, cyc);
      end else if (e.lane) begin
        if ({txdata, txcharisk} !== {e.d, e.k} ||
            {sync_ack, sync_done, sync_abort} !== e.p) begin
          nerr++;
          $display("FAIL lane cyc=%0d got %h/%b p=%b want %h/%b p=%b",
                   cyc, txdata, txcharisk,
                   {sync_ack, sync_done, sync_abort},
                   e.d, e.k, e.p);
        end
      end else if (din_ready !== e.r) begin
        nerr++;
        $display("FAIL din_ready cyc=%0d got %b want %b",
                 cyc, din_ready, e.r);
      end
    end
  end

  task automatic vec(
    input logic        al,
    input logic        ar,
    input logic        sr,
    input logic        dv,
    input logic [15:0] d,
    input logic [15:0] ed,
    input logic [1:0]  ek,
    input logic [2:0]  ep,
    input logic        er
  );
    rxbyteisaligned = al;
    alignrequest    = ar;
    sync_req        = sr;
    din_valid       = dv;
    din             = d;
    q.push_back('{cyc, 1'b0, 16'd0, 2'b00, 3'b000, er});
    q.push_back('{cyc + 1, 1'b1, ed, ek, ep, 1'b0});
    @(posedge txclk);
    #1;
  endtask

  task automatic idle();
    vec(1, 0, 0, 0, 16'd0, C16, 2'b01, 3'b000, 1);
  endtask

  task automatic frame_tail(input int from);
    for (int i = from; i < 7; i++)
      vec(1, 0, 0, 0, 16'd0, FW[i], 2'b00, 3'b000, 0);
    vec(1, 0, 0, 0, 16'd0, FW[7], 2'b00, 3'b010, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge txclk);
    #1;
    // reset and unaligned
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++)
      vec(0, 0, 0, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    vec(1, 0, 0, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    idle();

    // plain frame
    vec(1, 0, 1, 0, 16'd0, FW[0], 2'b00, 3'b100, 0);
    vec(1, 0, 1, 0, 16'd0, FW[1], 2'b00, 3'b000, 0);
    frame_tail(2);
    idle();

    // data stream interrupted by a frame, then gap comma
    for (int i = 0; i < 3; i++)
      vec(1, 0, 0, 1, 16'h1000 + 16'(i),
          16'h1000 + 16'(i), 2'b00, 3'b000, 1);
    vec(1, 0, 1, 1, 16'h1003, FW[0], 2'b00, 3'b100, 0);
    for (int i = 1; i < 7; i++)
      vec(1, 0, 0, 1, 16'h1003, FW[i], 2'b00, 3'b000, 0);
    vec(1, 0, 0, 1, 16'h1003, FW[7], 2'b00, 3'b010, 0);
    for (int i = 3; i < 8; i++)
      vec(1, 0, 0, 1, 16'h1000 + 16'(i),
          16'h1000 + 16'(i), 2'b00, 3'b000, 1);
    vec(1, 0, 0, 1, 16'h1008, C16, 2'b01, 3'b000, 0);
    vec(1, 0, 0, 1, 16'h1008, 16'h1008, 2'b00, 3'b000, 1);
    idle();

    // pure data: comma after every 16 words
    for (int i = 0; i < 16; i++)
      vec(1, 0, 0, 1, 16'h2000 + 16'(i),
          16'h2000 + 16'(i), 2'b00, 3'b000, 1);
    vec(1, 0, 0, 1, 16'h2010, C16, 2'b01, 3'b000, 0);
    vec(1, 0, 0, 1, 16'h2010, 16'h2010, 2'b00, 3'b000, 1);
    idle();

    // alignrequest stalls the frame at idx 3
    vec(1, 0, 1, 0, 16'd0, FW[0], 2'b00, 3'b100, 0);
    vec(1, 0, 0, 0, 16'd0, FW[1], 2'b00, 3'b000, 0);
    vec(1, 0, 0, 0, 16'd0, FW[2], 2'b00, 3'b000, 0);
    vec(1, 1, 0, 0, 16'd0, C16, 2'b01, 3'b000, 0);
    vec(1, 1, 0, 0, 16'd0, C16, 2'b01, 3'b000, 0);
    frame_tail(3);
    idle();

    // alignment loss at idx 5, then resend from idx 0
    vec(1, 0, 1, 0, 16'd0, FW[0], 2'b00, 3'b100, 0);
    for (int i = 1; i < 5; i++)
      vec(1, 0, 1, 0, 16'd0, FW[i], 2'b00, 3'b000, 0);
    vec(0, 0, 1, 0, 16'd0, A16, 2'b01, 3'b001, 0);
    vec(0, 0, 1, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    vec(1, 0, 1, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    vec(1, 0, 1, 0, 16'd0, FW[0], 2'b00, 3'b100, 0);
    vec(1, 0, 1, 0, 16'd0, FW[1], 2'b00, 3'b000, 0);
    frame_tail(2);
    idle();

    // async reset mid-frame
    vec(1, 0, 1, 0, 16'd0, FW[0], 2'b00, 3'b100, 0);
    vec(1, 0, 0, 0, 16'd0, FW[1], 2'b00, 3'b000, 0);
    vec(1, 0, 0, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    rstn = 1'b0;
    vec(1, 0, 0, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    rstn = 1'b1;
    vec(1, 0, 0, 0, 16'd0, A16, 2'b01, 3'b000, 0);
    idle();
    vec(1, 0, 0, 0, 16'd0, C16, 2'b01, 3'b000, 1);

    repeat (3) @(posedge txclk);
    #1;
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
